// File: rtl/dcu_iq.sv
// dcu_iq: RV32I decode unit; each beat is decoded on entry to a DEPTH-entry queue feeding the DPU.
// Optional DCU_BYPASS_EN: an empty queue forwards the incoming beat to the outputs in the same cycle.
module dcu_iq #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned GHSR_WIDTH = 8,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  fclk_i,
    input  logic                  rst_i,
    input  logic [INST_WIDTH-1:0] pfu_inst_i,
    input  logic [GHSR_WIDTH-1:0] pfu_ghsr_i,
    input  logic [PC_WIDTH-1:0]   pfu_pc_i,
    input  logic                  pfu_j_b_en_i,
    input  logic                  pfu_vld_i,
    output logic                  dcu_rdy_o,
    output logic                  dcu_vld_o,
    input  logic                  dpu_rdy_i,
    output logic [INST_WIDTH-1:0] dcu_inst_o,
    output logic [PC_WIDTH-1:0]   dcu_pc_o,
    output logic [GHSR_WIDTH-1:0] dcu_ghsr_o,
    output logic                  dcu_j_b_en_o,
    output logic [3:0]            dcu_op_class_o,
    output logic [XLEN-1:0]       dcu_imm_o,
    output logic [4:0]            dcu_rs1_o,
    output logic [4:0]            dcu_rs2_o,
    output logic [4:0]            dcu_rd_o,
    output logic                  dcu_wr_o,
    output logic                  dcu_illegal_o,
    input  logic                  stc_stall_i,
    input  logic                  stc_redirect_i
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [3:0] ClsIntI    = 4'd0;
    localparam logic [3:0] ClsIntR    = 4'd1;
    localparam logic [3:0] ClsLoad    = 4'd2;
    localparam logic [3:0] ClsStore   = 4'd3;
    localparam logic [3:0] ClsLui     = 4'd4;
    localparam logic [3:0] ClsAuipc   = 4'd5;
    localparam logic [3:0] ClsBranch  = 4'd6;
    localparam logic [3:0] ClsJal     = 4'd7;
    localparam logic [3:0] ClsJalr    = 4'd8;
    localparam logic [3:0] ClsFence   = 4'd9;
    localparam logic [3:0] ClsSystem  = 4'd10;
    localparam logic [3:0] ClsIllegal = 4'd15;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [PC_WIDTH-1:0]   pc;
        logic [GHSR_WIDTH-1:0] ghsr;
        logic                  j_b_en;
        logic [3:0]            op_class;
        logic [XLEN-1:0]       imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic                  wr;
        logic                  illegal;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    entry_t          dec, head;
    logic            empty, bypass, enq, deq;

    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [3:0]      cls;
    logic            legal, use_rs1, use_rs2, use_rd, writes_rd;

    assign funct7 = pfu_inst_i[31:25];
    assign funct3 = pfu_inst_i[14:12];
    assign imm_i  = XLEN'($signed(pfu_inst_i[31:20]));
    assign imm_s  = XLEN'($signed({pfu_inst_i[31:25], pfu_inst_i[11:7]}));
    assign imm_b  = XLEN'($signed({pfu_inst_i[31], pfu_inst_i[7], pfu_inst_i[30:25],
                                   pfu_inst_i[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({pfu_inst_i[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({pfu_inst_i[31], pfu_inst_i[19:12], pfu_inst_i[20],
                                   pfu_inst_i[30:21], 1'b0}));

    always_comb begin
        legal     = (pfu_inst_i[1:0] == 2'b11);
        cls       = ClsIllegal;
        imm       = '0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        writes_rd = 1'b0;
        case (pfu_inst_i[6:2])
            5'b00100: begin
                {cls, imm, use_rs1, use_rd, writes_rd} = {ClsIntI, imm_i, 3'b111};
                if (funct3 == 3'b001 && funct7 != 7'b0000000) legal = 1'b0;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    legal = 1'b0;
            end
            5'b01100: begin
                {cls, use_rs1, use_rs2, use_rd, writes_rd} = {ClsIntR, 4'b1111};
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    legal = 1'b0;
            end
            5'b00000: {cls, imm, use_rs1, use_rd, writes_rd} = {ClsLoad, imm_i, 3'b111};
            5'b01000: {cls, imm, use_rs1, use_rs2}           = {ClsStore, imm_s, 2'b11};
            5'b01101: {cls, imm, use_rd, writes_rd}          = {ClsLui, imm_u, 2'b11};
            5'b00101: {cls, imm, use_rd, writes_rd}          = {ClsAuipc, imm_u, 2'b11};
            5'b11000: {cls, imm, use_rs1, use_rs2}           = {ClsBranch, imm_b, 2'b11};
            5'b11011: {cls, imm, use_rd, writes_rd}          = {ClsJal, imm_j, 2'b11};
            5'b11001: {cls, imm, use_rs1, use_rd, writes_rd} = {ClsJalr, imm_i, 3'b111};
            5'b00011: {cls, imm, use_rs1, use_rd}            = {ClsFence, imm_i, 2'b11};
            5'b11100: {cls, imm, use_rs1, use_rd}            = {ClsSystem, imm_i, 2'b11};
            default:  legal = 1'b0;
        endcase
    end

    // Illegal entries keep inst/pc/ghsr for the trap path but carry no operands.
    always_comb begin
        dec        = '0;
        dec.inst   = pfu_inst_i;
        dec.pc     = pfu_pc_i;
        dec.ghsr   = pfu_ghsr_i;
        dec.j_b_en = pfu_j_b_en_i;
        if (legal) begin
            dec.op_class = cls;
            dec.imm      = imm;
            dec.rs1      = use_rs1 ? pfu_inst_i[19:15] : 5'd0;
            dec.rs2      = use_rs2 ? pfu_inst_i[24:20] : 5'd0;
            dec.rd       = use_rd  ? pfu_inst_i[11:7]  : 5'd0;
            dec.wr       = writes_rd && (pfu_inst_i[11:7] != 5'd0);
        end else begin
            dec.op_class = ClsIllegal;
            dec.illegal  = 1'b1;
        end
    end

    assign empty = (count_q == '0);
`ifdef DCU_BYPASS_EN
    assign bypass = empty && pfu_vld_i;
`else
    assign bypass = 1'b0;
`endif

    assign head      = bypass ? dec : mem_q[rd_ptr_q];
    assign dcu_rdy_o = (count_q < CW'(DEPTH)) && !stc_redirect_i;
    assign dcu_vld_o = (!empty || bypass) && !stc_stall_i && !stc_redirect_i;
    assign deq       = dcu_vld_o && dpu_rdy_i && !bypass;
    // A bypassed beat taken by the DPU is consumed directly and never stored.
    assign enq       = pfu_vld_i && dcu_rdy_o && !(bypass && dcu_vld_o && dpu_rdy_i);

    always_ff @(posedge fclk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (stc_redirect_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                mem_q[wr_ptr_q] <= dec;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (enq && !deq)      count_q <= count_q + CW'(1);
            else if (deq && !enq) count_q <= count_q - CW'(1);
        end
    end

    assign dcu_inst_o     = head.inst;
    assign dcu_pc_o       = head.pc;
    assign dcu_ghsr_o     = head.ghsr;
    assign dcu_j_b_en_o   = head.j_b_en;
    assign dcu_op_class_o = head.op_class;
    assign dcu_imm_o      = head.imm;
    assign dcu_rs1_o      = head.rs1;
    assign dcu_rs2_o      = head.rs2;
    assign dcu_rd_o       = head.rd;
    assign dcu_wr_o       = head.wr;
    assign dcu_illegal_o  = head.illegal;

endmodule
